// File: rtl/synth_pkg.sv
// synth_pkg: shared state encoding, note width, rest code and tempo helper
// for the step sequencer.
package synth_pkg;
   localparam int NOTE_W = 7;
   localparam logic [NOTE_W-1:0] REST = '0;
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_NOTE_ON  = 2'd1;
   localparam logic [1:0] ST_NOTE_OFF = 2'd2;
   // NOTE_ON length in ticks: tempo 0 behaves as 1, and at least one tick always
   function automatic logic [7:0] on_ticks(input logic [7:0] t);
      return (t < 8'd3) ? 8'd1 : t - 8'd1;
   endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: counts 0..TICK_DIV-1 while enabled and pulses tick on the wrap.
module tick_prescaler #(
   parameter int TICK_DIV = 500000
) (
   input  logic CLK_50_MHz,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);
   localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   logic [W-1:0] cnt;
   assign tick = enable && cnt == W'(TICK_DIV - 1);
   always_ff @(posedge CLK_50_MHz or posedge reset)
      if (reset) cnt <= '0;
      else if (clear) cnt <= '0;
      else if (enable) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/step_sequencer_ctrl.sv
// step_sequencer_ctrl: pattern RAM plus NOTE_ON/NOTE_OFF step player.
// Define STEP_SEQ_LOOP_EN to wrap from the last step back to step 0.
module step_sequencer_ctrl
   import synth_pkg::*;
#(
   parameter int TICK_DIV  = 500000,
   parameter int NUM_STEPS = 16
) (
   input  logic                         CLK_50_MHz,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         stop,
   input  logic [7:0]                   tempo_ticks,
   input  logic                         wr_en,
   input  logic [$clog2(NUM_STEPS)-1:0] wr_addr,
   input  logic [NOTE_W-1:0]            wr_note,
   output logic [NOTE_W-1:0]            note,
   output logic                         gate,
   output logic [$clog2(NUM_STEPS)-1:0] step_idx,
   output logic                         busy,
   output logic                         tick
);
   localparam int AW = $clog2(NUM_STEPS);
`ifdef STEP_SEQ_LOOP_EN
   localparam logic LOOP = 1'b1;
`else
   localparam logic LOOP = 1'b0;
`endif
   logic [1:0]        state;
   logic [7:0]        on_len;
   logic [7:0]        tcnt;
   logic [NOTE_W-1:0] ram [NUM_STEPS];
   logic              go;
   logic              last;
   logic [AW-1:0]     next_idx;
   assign go       = start && !stop && state == ST_IDLE;
   assign last     = step_idx == AW'(NUM_STEPS - 1);
   assign next_idx = step_idx + 1'b1;
   assign busy     = state != ST_IDLE;
   assign gate     = state == ST_NOTE_ON && note != REST;
   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
      .CLK_50_MHz(CLK_50_MHz),
      .reset     (reset),
      .clear     (go),
      .enable    (busy),
      .tick      (tick)
   );
   // RAM is read only when a step loads, so writes to the playing step wait for its next load
   always_ff @(posedge CLK_50_MHz or posedge reset)
      if (reset) begin
         state    <= ST_IDLE;
         note     <= REST;
         step_idx <= '0;
         on_len   <= 8'd1;
         tcnt     <= '0;
         for (int i = 0; i < NUM_STEPS; i++) ram[i] <= REST;
      end else begin
         if (wr_en) ram[wr_addr] <= wr_note;
         if (state == ST_IDLE) begin
            if (go) begin
               state    <= ST_NOTE_ON;
               step_idx <= '0;
               note     <= ram[0];
               on_len   <= on_ticks(tempo_ticks);
               tcnt     <= '0;
            end
         end else if (stop) state <= ST_IDLE;
         else if (tick) begin
            if (state == ST_NOTE_ON) begin
               if (tcnt == on_len - 8'd1) begin
                  state <= ST_NOTE_OFF;
                  tcnt  <= '0;
               end else tcnt <= tcnt + 8'd1;
            end else if (last && !LOOP) state <= ST_IDLE;
            else begin
               state    <= ST_NOTE_ON;
               step_idx <= next_idx;
               note     <= ram[next_idx];
               on_len   <= on_ticks(tempo_ticks);
               tcnt     <= '0;
            end
         end
      end
endmodule

// File: tb/tb_step_sequencer_ctrl.sv
// tb_step_sequencer_ctrl: scoreboard bench; expected output changes are queued
// by the stimulus and checked by a monitor whenever the observed outputs change.
module tb_step_sequencer_ctrl;
   logic       clk = 0, reset = 0;
   logic       start = 0, stop = 0, wr_en = 0;
   logic [7:0] tempo = 0;
   logic [3:0] wr_addr = 0;
   logic [6:0] wr_note = 0;
   logic [6:0] note;
   logic       gate, busy, tick;
   logic [3:0] step_idx;
   logic       start4 = 0, stop4 = 0, wr_en4 = 0;
   logic [7:0] tempo4 = 0;
   logic [1:0] wr_addr4 = 0;
   logic [6:0] wr_note4 = 0;
   logic [6:0] note4;
   logic       gate4, busy4, tick4;
   logic [1:0] step_idx4;

   always #5 clk = ~clk;

   step_sequencer_ctrl #(.TICK_DIV(4), .NUM_STEPS(16)) dut (
      .CLK_50_MHz(clk), .reset(reset), .start(start), .stop(stop),
      .tempo_ticks(tempo), .wr_en(wr_en), .wr_addr(wr_addr), .wr_note(wr_note),
      .note(note), .gate(gate), .step_idx(step_idx), .busy(busy), .tick(tick)
   );
   step_sequencer_ctrl #(.TICK_DIV(2), .NUM_STEPS(4)) dut4 (
      .CLK_50_MHz(clk), .reset(reset), .start(start4), .stop(stop4),
      .tempo_ticks(tempo4), .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_note(wr_note4),
      .note(note4), .gate(gate4), .step_idx(step_idx4), .busy(busy4), .tick(tick4)
   );

   typedef struct {logic [23:0] s; int len;} exp_t;
   exp_t        q[$];
   logic [12:0] m_last = 0;
   logic [10:0] d_last = 0;
   logic [23:0] prev = '1, cur;
   int total = 0, bad = 0, ticks = 0, run = 0, evn = 0, t0 = 0;

   task automatic check(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   task automatic exp_m(input int len, input logic b, g, input logic [6:0] n, input logic [3:0] s);
      exp_t e;
      m_last = {b, g, n, s};
      e.s = {m_last, d_last};
      e.len = len;
      q.push_back(e);
   endtask

   task automatic exp_d(input int len, input logic b, g, input logic [6:0] n, input logic [1:0] s);
      exp_t e;
      d_last = {b, g, n, s};
      e.s = {m_last, d_last};
      e.len = len;
      q.push_back(e);
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         cur = {busy, gate, note, step_idx, busy4, gate4, note4, step_idx4};
         if (tick) ticks++;
         if (cur !== prev) begin
            if (q.size() == 0) check("unexpected_change", int'(cur), int'(prev));
            else begin
               e = q.pop_front();
               evn++;
               check($sformatf("event%0d_outputs", evn), int'(cur), int'(e.s));
               if (e.len != 0) check($sformatf("event%0d_cycles", evn), run, e.len);
            end
            run = 1;
            prev = cur;
         end else run++;
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic go();
      start = 1; @(negedge clk); start = 0;
   endtask
   task automatic halt();
      stop = 1; @(negedge clk); stop = 0;
   endtask
   task automatic wr(input logic [3:0] a, input logic [6:0] n);
      wr_en = 1; wr_addr = a; wr_note = n; @(negedge clk); wr_en = 0;
   endtask
   task automatic go4();
      start4 = 1; @(negedge clk); start4 = 0;
   endtask
   task automatic halt4();
      stop4 = 1; @(negedge clk); stop4 = 0;
   endtask
   task automatic wr4(input logic [1:0] a, input logic [6:0] n);
      wr_en4 = 1; wr_addr4 = a; wr_note4 = n; @(negedge clk); wr_en4 = 0;
   endtask

   initial begin
      exp_m(0, 0, 0, 0, 0);
      fork
         monitor();
      join_none
      #1 reset = 1;
      cyc(2);
      reset = 0;
      wr(0, 60); wr(1, 0); wr(2, 64); wr(3, 70); wr(5, 72);
      // tempo 3: 8 cycles on, 4 off, rest step silent for 12
      tempo = 3;
      exp_m(0, 1, 1, 60, 0); exp_m(8, 1, 0, 60, 0); exp_m(4, 1, 0, 0, 1);
      exp_m(12, 1, 1, 64, 2); exp_m(8, 1, 0, 64, 2); exp_m(4, 1, 1, 70, 3);
      exp_m(2, 0, 0, 70, 3);
      t0 = ticks;
      go();
      cyc(37);
      halt();
      cyc(2);
      check("ticks_while_busy", ticks - t0, 9);
      // start and stop together in IDLE
      start = 1; stop = 1; @(negedge clk); start = 0; stop = 0;
      cyc(3);
      check("start_stop_idle_busy", int'(busy), 0);
      // tempo 0 then tempo 1: one tick on, one tick off
      tempo = 0;
      exp_m(0, 1, 1, 60, 0); exp_m(4, 1, 0, 60, 0); exp_m(4, 1, 0, 0, 1);
      exp_m(8, 1, 1, 64, 2); exp_m(4, 1, 0, 64, 2); exp_m(4, 1, 1, 70, 3);
      exp_m(4, 1, 0, 70, 3); exp_m(4, 1, 0, 0, 4); exp_m(2, 0, 0, 0, 4);
      go();
      cyc(10);
      tempo = 1;
      cyc(23);
      halt();
      cyc(3);
      // stop in the second NOTE_ON tick of step 5; the write to step 5 must not show
      tempo = 3;
      exp_m(0, 1, 1, 60, 0); exp_m(8, 1, 0, 60, 0); exp_m(4, 1, 0, 0, 1);
      exp_m(12, 1, 1, 64, 2); exp_m(8, 1, 0, 64, 2); exp_m(4, 1, 1, 70, 3);
      exp_m(8, 1, 0, 70, 3); exp_m(4, 1, 0, 0, 4); exp_m(12, 1, 1, 72, 5);
      exp_m(6, 0, 0, 72, 5);
      go();
      cyc(62);
      wr(5, 10);
      cyc(2);
      halt();
      cyc(3);
      // reset in the middle of NOTE_ON
      exp_m(0, 1, 1, 60, 0); exp_m(3, 0, 0, 0, 0);
      go();
      cyc(2);
      #2 reset = 1;
      #1 check("reset_outputs", int'({note, gate, step_idx, busy, tick}), 0);
      t0 = ticks;
      @(negedge clk);
      cyc(1);
      reset = 0;
      wr(0, 50);
      cyc(3);
      check("no_tick_after_reset", ticks, t0);
      exp_m(0, 1, 1, 50, 0); exp_m(6, 0, 0, 50, 0);
      go();
      cyc(5);
      halt();
      cyc(3);
      // four-step instance: end of pattern, with or without looping
      wr4(0, 1); wr4(1, 2); wr4(2, 3); wr4(3, 4);
      exp_d(0, 1, 1, 1, 0); exp_d(2, 1, 0, 1, 0); exp_d(2, 1, 1, 2, 1);
      exp_d(2, 1, 0, 2, 1); exp_d(2, 1, 1, 3, 2); exp_d(2, 1, 0, 3, 2);
      exp_d(2, 1, 1, 4, 3); exp_d(2, 1, 0, 4, 3);
`ifdef STEP_SEQ_LOOP_EN
      exp_d(2, 1, 1, 1, 0); exp_d(2, 0, 0, 1, 0);
`else
      exp_d(2, 0, 0, 4, 3);
`endif
      go4();
      cyc(17);
      halt4();
      cyc(6);
      check("events_outstanding", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/step_sequencer_ctrl.md
STEP_SEQUENCER_CTRL -- requirements
Module: step_sequencer_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 500000, meaning CLK_50_MHz cycles per tick (100 Hz).
REQ-002 SHALL have parameter NUM_STEPS, default 16, meaning pattern length (power of two).
REQ-003 SHALL have port CLK_50_MHz  in  1  system clock (one clock); all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  in  1  single-cycle pulse; begin playback at step 0.
REQ-006 SHALL have port stop  in  1  single-cycle pulse; end playback.
REQ-007 SHALL have port tempo_ticks  in  8  ticks per step.
REQ-008 SHALL have port wr_en  in  1  pattern RAM write strobe.
REQ-009 SHALL have port wr_addr  in  log2(NUM_STEPS)  pattern step address.
REQ-010 SHALL have port wr_note  in  7  note code; 0 = rest.
REQ-011 SHALL have port note  out  7  current note code.
REQ-012 SHALL have port gate  out  1  note sounding.
REQ-013 SHALL have port step_idx  out  log2(NUM_STEPS)  current step.
REQ-014 SHALL have port busy  out  1  playback active.
REQ-015 SHALL have port tick  out  1  one-cycle pulse every TICK_DIV cycles while busy.

Function
REQ-016 SHALL use states IDLE, NOTE_ON and NOTE_OFF.
REQ-017 SHALL run a prescaler counting 0..TICK_DIV-1 only while busy; tick SHALL pulse on the wrap, and the prescaler SHALL be cleared on start.
REQ-018 SHALL, on start in IDLE, load step 0, sample tempo_ticks, and enter NOTE_ON on the next edge; busy=1 and gate reflect the new step in that same cycle (1-cycle latency).
REQ-019 SHALL treat tempo_ticks=0 as 1.
REQ-020 SHALL hold NOTE_ON for max(T-1,1) ticks and NOTE_OFF for exactly 1 tick, where T is the sampled tempo.
REQ-021 SHALL, after NOTE_OFF, advance step_idx, resample tempo_ticks, and re-enter NOTE_ON.
REQ-022 SHALL drive gate=1 only in NOTE_ON with note≠0; a rest SHALL keep gate=0 for the whole step.
REQ-023 SHALL hold note at the current step's value through NOTE_OFF.
REQ-024 SHALL write pattern RAM at any time; a write to the playing step SHALL take effect only at that step's next load.
REQ-025 SHALL give stop priority over a simultaneous start: the next state is IDLE, gate=0, busy=0, and note and step_idx are held.
REQ-026 SHALL ignore start while busy.
REQ-027 SHALL ignore stop in IDLE.
REQ-028 SHALL, in IDLE, keep tick=0 and the prescaler frozen.

Reset
REQ-029 SHALL, asynchronously on reset, force state IDLE, note=0, gate=0, step_idx=0, busy=0, tick=0, and prescaler=0.
REQ-030 SHALL clear pattern RAM contents to 0 on reset; reset mid-playback SHALL abort immediately, with no further tick.

Configuration
REQ-031 SHALL, with STEP_SEQ_LOOP_EN defined, wrap from step NUM_STEPS-1 to step 0 and continue playing.
REQ-032 SHALL, without STEP_SEQ_LOOP_EN, return to IDLE after NOTE_OFF of step NUM_STEPS-1, with busy=0 on the following cycle and step_idx held at NUM_STEPS-1.

Structure
REQ-033 SHALL place the state encoding, note width (7) and the rest code (0) in shared package synth_pkg.
REQ-034 SHALL implement the prescaler as sub-module tick_prescaler with parameter TICK_DIV, inputs clear/enable, and output tick.

Verification
REQ-035 SHALL verify, with TICK_DIV=4, tempo=3, steps 0..2 = 60,0,64 and start: gate high 8 cycles at note 60, low 4 cycles, low 12 cycles for the rest step, then high for note 64.
REQ-036 SHALL verify start and stop asserted in the same cycle in IDLE -> busy stays 0.
REQ-037 SHALL verify stop in the 2nd tick of NOTE_ON at step 5 -> the next cycle has gate=0, busy=0, and step_idx=5.
REQ-038 SHALL verify tempo=0 and tempo=1 -> NOTE_ON lasts 1 tick and NOTE_OFF lasts 1 tick per step.
REQ-039 SHALL verify NUM_STEPS=4 with loop defined -> step_idx sequence 0,1,2,3,0; without loop -> busy falls after step 3.
REQ-040 SHALL verify reset pulsed mid-NOTE_ON -> all outputs 0 immediately and no tick thereafter; start afterwards plays step 0.
